// File: rtl/instr_mem_if.sv
// Instruction memory request/acknowledge bus between the fetch unit and memory.
// The master holds req with a stable addr until a one-cycle ack returns rdata.
interface instr_mem_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ack;
    logic [7:0]        rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: program counter, instruction register and a one-entry
// prefetch buffer filled from instruction memory over a req/ack handshake.
module instr_fetch_unit #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ir_load,
    input  logic              pc_load,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    instr_mem_if.master       mem,
    output logic [7:0]        IR,
    output logic              ir_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_busy
);

    typedef enum logic [1:0] {StIdle, StReq, StFull, StFlush} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        ir_q, ir_d;
    logic              ir_valid_q, ir_valid_d;
    logic [7:0]        buf_q, buf_d;
    logic              buf_valid_q, buf_valid_d;
    logic              load_pending_q, load_pending_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

    logic              pc_change;
    logic [ADDR_W-1:0] pc_next;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            pc_q           <= ADDR_W'(RESET_PC);
            ir_q           <= '0;
            ir_valid_q     <= 1'b0;
            buf_q          <= '0;
            buf_valid_q    <= 1'b0;
            load_pending_q <= 1'b0;
            mem_req_q      <= 1'b0;
            mem_addr_q     <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            ir_q           <= ir_d;
            ir_valid_q     <= ir_valid_d;
            buf_q          <= buf_d;
            buf_valid_q    <= buf_valid_d;
            load_pending_q <= load_pending_d;
            mem_req_q      <= mem_req_d;
            mem_addr_q     <= mem_addr_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        ir_d           = ir_q;
        ir_valid_d     = ir_valid_q;
        buf_d          = buf_q;
        buf_valid_d    = buf_valid_q;
        load_pending_d = load_pending_q;
        mem_req_d      = mem_req_q;
        mem_addr_d     = mem_addr_q;

        pc_change = jump_en | pc_load;
        pc_next   = jump_en ? jump_addr : pc_q + ADDR_W'(1);

        if (pc_change) begin
            pc_d        = pc_next;
            buf_valid_d = 1'b0;
        end

        // IR takes the old buffer even when the PC advances on the same edge.
        if (ir_load && buf_valid_q) begin
            ir_d       = buf_q;
            ir_valid_d = 1'b1;
        end else if (ir_load) begin
            load_pending_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                state_d    = StReq;
                mem_req_d  = 1'b1;
                mem_addr_d = pc_d;
            end
            StReq: begin
                if (mem.ack) begin
                    if (load_pending_q || ir_load) begin
                        ir_d           = mem.rdata;
                        ir_valid_d     = 1'b1;
                        load_pending_d = 1'b0;
                    end
                    if (pc_change) begin
                        // Data belongs to the old PC: do not validate, re-request at once.
                        mem_addr_d = pc_next;
                    end else begin
                        buf_d       = mem.rdata;
                        buf_valid_d = 1'b1;
                        mem_req_d   = 1'b0;
                        state_d     = StFull;
                    end
                end else if (pc_change) begin
                    state_d = StFlush;
                end
            end
            StFull: begin
                if (pc_change) begin
                    state_d    = StReq;
                    mem_req_d  = 1'b1;
                    mem_addr_d = pc_next;
                end
            end
            StFlush: begin
                // Stale data is dropped; the request stays up until its ack.
                if (mem.ack) begin
                    state_d    = StReq;
                    mem_addr_d = pc_d;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign mem.req    = mem_req_q;
    assign mem.addr   = mem_addr_q;
    assign IR         = ir_q;
    assign ir_valid   = ir_valid_q;
    assign pc         = pc_q;
    assign fetch_busy = load_pending_q;

endmodule
